// File: rtl/fetch_sequencer_pkg.sv
// Shared CPU definitions: opcode constants, bus width defaults and fetch state encodings.
package fetch_sequencer_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;

    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction fetch: owns the PC, reads the combinational ROM, registers instr for the decoder.
// Latency: PC -> instr_valid in 1 clk, 1 instr/clk while instr_ready is high.
// Backpressure: single-entry output register holds instr and PC while !instr_ready.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int              ADDR_W     = ADDR_W_DEF,
    parameter int              DATA_W     = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [3:0]      HLT_OPCODE = OP_HLT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect_en,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              halted,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] PC_ONE = 1;

    fetch_state_t      state, state_nxt;
    logic [ADDR_W-1:0] pc;
    logic              load;
    logic              take_redirect;
    logic              hlt_capture;

    assign rom_addr      = pc;
    assign halted        = (state == ST_HALT);
    assign busy          = (state == ST_FETCH);

    // Redirect outranks capture; HALT is terminal so redirects there are dropped.
    assign take_redirect = redirect_en && (state != ST_HALT);
    assign load          = (state == ST_FETCH) && (!instr_valid || instr_ready);
    assign hlt_capture   = load && !take_redirect && (rom_data[DATA_W-1 -: 4] == HLT_OPCODE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start)       state_nxt = ST_FETCH;
            ST_FETCH: if (hlt_capture) state_nxt = ST_HALT;
            ST_HALT:  state_nxt = ST_HALT;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else if (take_redirect) begin
            pc          <= redirect_addr;
            instr_valid <= 1'b0;
        end else if (load) begin
            instr       <= rom_data;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            if (!hlt_capture) begin
                pc <= pc + PC_ONE;
            end
        end else if (instr_valid && instr_ready) begin
            // Only reachable in HALT: the HLT word drains and nothing replaces it.
            instr_valid <= 1'b0;
        end
    end

endmodule
